// File: rtl/uart_rx_if.sv
// Serial receive link: the Rx pin plus the received-byte and status outputs of uart_rx.
// The master modport is the receiver side.
interface uart_rx_if;
  logic       Rx;
  logic [7:0] O_DATA;
  logic       NrD;
  logic       RiP;
  logic       FE;

  modport master (input Rx, output O_DATA, output NrD, output RiP, output FE);
  modport slave  (output Rx, input O_DATA, input NrD, input RiP, input FE);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling at BAUD_DIVIDER clocks per bit.
// Define UART_RX_FRAME_ERR_EN to report low stop bits on FE instead of accepting the byte.
module uart_rx #(
  parameter int BAUD_DIVIDER = 9
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  bus,
  output logic [1:0] o_dbg_state
);
  localparam int TW = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
  // The timer counts down to zero, so it is loaded with one less than the interval.
  localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIVIDER / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIVIDER - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nx;
  logic          r_sync1, r_sync2;
  logic          w_rxs;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [7:0]    r_data, w_data_nx;
  logic          r_nrd, w_nrd_nx;
  logic          w_expire;
`ifdef UART_RX_FRAME_ERR_EN
  logic          r_fe, w_fe_nx;
`endif

  assign w_rxs    = r_sync2;
  assign w_expire = (r_timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_nrd   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_fe    <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.Rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_nrd   <= w_nrd_nx;
`ifdef UART_RX_FRAME_ERR_EN
      r_fe    <= w_fe_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = w_expire ? r_timer : r_timer - TW'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_nrd_nx   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    w_fe_nx    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_timer_nx = HALF_M1;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (w_rxs) begin
            w_state_nx = S_IDLE;
          end else begin
            w_timer_nx = FULL_M1;
            w_bit_nx   = '0;
            w_state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_nx = {w_rxs, r_shift[7:1]};
          w_timer_nx = FULL_M1;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
          else               w_bit_nx   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets an immediately following start bit be caught.
        if (w_expire) begin
          w_state_nx = S_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (w_rxs) begin
            w_data_nx = r_shift;
            w_nrd_nx  = 1'b1;
          end else begin
            w_fe_nx   = 1'b1;
          end
`else
          w_data_nx = r_shift;
          w_nrd_nx  = 1'b1;
`endif
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.O_DATA  = r_data;
  assign bus.NrD     = r_nrd;
  assign bus.RiP     = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
`ifdef UART_RX_FRAME_ERR_EN
  assign bus.FE      = r_fe;
`else
  assign bus.FE      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus random frames
// scored against a frame-level model of what the receiver must report.
module tb_uart_rx;
  localparam int BD   = 9;
  localparam int HALF = BD / 2;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  uart_rx_if bus();

  uart_rx #(.BAUD_DIVIDER(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  // scoreboard state
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         nrd_exp = 0, nrd_seen = 0;
  int         fe_exp  = 0, fe_seen  = 0;
  int         t_prev  = 0, t_last   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: a good stop bit (or no frame checking) delivers the byte, else one FE.
  task automatic expect_frame(input logic [7:0] d, input bit stop);
    if (stop || !FE_EN) begin
      exp_q.push_back(d);
      nrd_exp++;
      last_good = d;
    end else begin
      fe_exp++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.NrD) begin
        nrd_seen++;
        t_prev = t_last;
        t_last = cyc;
        if (exp_q.size() == 0) chk("nrd_unexpected", {31'b0, bus.NrD}, 32'd0);
        else                   chk("rx_byte", {24'b0, bus.O_DATA}, {24'b0, exp_q.pop_front()});
      end
      if (bus.FE) fe_seen++;
    end
  end

  // drivers: each bit lasts BD clocks, starting 1 time unit after a rising edge
  task automatic drive_bit(input bit b);
    bus.Rx = b;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    expect_frame(d, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic end_check(input string tag);
    idle_bits(2);
    chk({tag, "_nrd_cnt"}, nrd_seen, nrd_exp);
    chk({tag, "_fe_cnt"}, fe_seen, fe_exp);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_data"}, {24'b0, bus.O_DATA}, {24'b0, last_good});
  endtask

  initial begin
    int         rip_err;
    int         nrd_at;
    int         rip_cnt;
    bit         stop;
    logic [7:0] d;

    rst    = 1'b1;
    bus.Rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", {24'b0, bus.O_DATA}, 32'h00);
    chk("reset_flags", {29'b0, bus.NrD, bus.RiP, bus.FE}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bits(2);

    // 0xA5 with exact output timing and RiP profile
    rip_err = 0;
    nrd_at  = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        // Rx falls just after edge 0; rxs is low in cycle T after edge 2.
        for (int k = 1; k <= 100; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (bus.NrD && nrd_at < 0) nrd_at = k;
          if (bus.RiP !== ((k >= 3) && (k <= 2 + HALF + 9 * BD))) rip_err++;
        end
      end
    join
    chk("a5_nrd_cycle", nrd_at, 2 + HALF + 9 * BD + 1);
    chk("a5_rip_profile", rip_err, 0);
    end_check("a5");

    // false start: 3 low cycles
    bus.Rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.Rx  = 1'b1;
    rip_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.RiP) rip_cnt++;
    end
    chk("false_rip_cycles", rip_cnt, HALF);
    @(posedge clk); #1;
    end_check("false");

    // low stop bit
    send_frame(8'h3C, 1'b0);
    end_check("stop0");

    // back-to-back, no idle
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    end_check("b2b");
    chk("b2b_gap", t_last - t_prev, 10 * BD);

    // reset during data bit 4 of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 1; i < 4; i++) drive_bit(1'b0);
    bus.Rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_data", {24'b0, bus.O_DATA}, 32'h00);
    chk("rst_mid_flags", {29'b0, bus.NrD, bus.RiP, bus.FE}, 32'd0);
    bus.Rx = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    last_good = 8'h00;
    idle_bits(2);
    send_frame(8'h7E, 1'b1);
    end_check("post_rst");

    // loopback-style pair from a transmitter with the same divider
    send_frame(8'h55, 1'b1);
    send_frame(8'hC3, 1'b1);
    end_check("loop");

    // random frames; a low stop bit needs at least one idle bit behind it
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop);
      idle_bits(stop ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    end_check("rand");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
